cpu_debug_ocimem_arbiter: RTL and testbench

CPU_DEBUG_OCIMEM_ARBITER -- requirements
Module: cpu_debug_ocimem_arbiter

---
 rtl/cpu_debug_ocimem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_cpu_debug_ocimem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_ocimem_arbiter.sv
// Arbitrates the OCI debug RAM between JTAG debug-slave strobes and the CPU debug-memory slave.
// JTAG load/write take 1 cycle, JTAG read 2 cycles; CPU write 0 wait states, CPU read 1 wait state.
// JTAG has priority; a held CPU request sees av_waitrequest. Macro CPU_DEBUG_OCIMEM_WP_EN enables write protect.
module cpu_debug_ocimem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic [37:0] jdo,
  input  logic        debugack,
  input  logic        clr_status,
  input  logic [7:0]  av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [31:0] av_writedata,
  input  logic [3:0]  av_byteenable,
  output logic [31:0] av_readdata,
  output logic        av_waitrequest,
  output logic [7:0]  ram_addr,
  output logic        ram_en,
  output logic        ram_wren,
  output logic [3:0]  ram_byteenable,
  output logic [31:0] ram_wrdata,
  input  logic [31:0] ram_rddata,
  output logic [31:0] MonDReg,
  output logic [7:0]  mon_addr,
  output logic        jtag_overrun,
  output logic        wp_violation
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CPU_RD  = 2'd1;
  localparam logic [1:0] ST_JTAG_RD = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  logic [1:0]  state, state_nxt;
  logic        slot_vld;
  logic [1:0]  slot_op;
  logic [31:0] slot_dat;
  logic        strb_any, strb_multi;
  logic [1:0]  strb_op;
  logic        in_idle, jtag_go, retire_lw, accept, bypass, overrun_set, wp_set;
  logic [1:0]  cur_op;
  logic [31:0] cur_dat;
  logic [7:0]  mon_addr_nxt;
  logic [31:0] mondreg_nxt;
  logic [5:0]  unused_jdo;

  assign unused_jdo = {jdo[37:35], jdo[2:0]};

  // Strobe decode: fixed priority a > b > no_action_a, anything beyond one strobe is an overrun.
  always_comb begin
    strb_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    strb_multi = (take_action_ocimem_a & take_action_ocimem_b) |
                 (take_action_ocimem_a & take_no_action_ocimem_a) |
                 (take_action_ocimem_b & take_no_action_ocimem_a);
    if (take_action_ocimem_a)      strb_op = OP_LOAD;
    else if (take_action_ocimem_b) strb_op = OP_WRITE;
    else                           strb_op = OP_READ;
  end

  // Slot bookkeeping. An empty slot in IDLE lets a fresh strobe execute directly (bypass);
  // a JTAG read keeps the slot occupied until its data is captured in JTAG_RD.
  always_comb begin
    in_idle     = (state == ST_IDLE);
    jtag_go     = in_idle && (slot_vld || strb_any);
    cur_op      = slot_vld ? slot_op  : strb_op;
    cur_dat     = slot_vld ? slot_dat : jdo[34:3];
    retire_lw   = in_idle && slot_vld && (slot_op != OP_READ);
    accept      = strb_any && (!slot_vld || retire_lw);
    bypass      = in_idle && !slot_vld && strb_any;
    overrun_set = strb_multi || (strb_any && !accept);
  end

  // Datapath and FSM next-state: RAM port steering, CPU handshake, monitor register updates.
  always_comb begin
    state_nxt      = state;
    ram_addr       = mon_addr;
    ram_en         = 1'b0;
    ram_wren       = 1'b0;
    ram_byteenable = 4'hF;
    ram_wrdata     = cur_dat;
    av_readdata    = 32'h0;
    av_waitrequest = av_read | av_write;
    mon_addr_nxt   = mon_addr;
    mondreg_nxt    = MonDReg;
    wp_set         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (jtag_go) begin
          case (cur_op)
            OP_LOAD: mon_addr_nxt = cur_dat[30:23];
            OP_WRITE: begin
              ram_en       = 1'b1;
              ram_wren     = 1'b1;
              mondreg_nxt  = cur_dat;
              mon_addr_nxt = mon_addr + 8'd1;
            end
            default: begin
              ram_en    = 1'b1;
              state_nxt = ST_JTAG_RD;
            end
          endcase
        end else if (av_read) begin
          ram_en    = 1'b1;
          ram_addr  = av_address;
          state_nxt = ST_CPU_RD;
        end else if (av_write) begin
          av_waitrequest = 1'b0;
          ram_addr       = av_address;
          ram_byteenable = av_byteenable;
          ram_wrdata     = av_writedata;
`ifdef CPU_DEBUG_OCIMEM_WP_EN
          if (debugack) begin
            ram_en   = 1'b1;
            ram_wren = 1'b1;
          end else begin
            wp_set = 1'b1;
          end
`else
          ram_en   = 1'b1;
          ram_wren = 1'b1;
`endif
        end
      end
      ST_CPU_RD: begin
        av_readdata    = ram_rddata;
        av_waitrequest = 1'b0;
        state_nxt      = ST_IDLE;
      end
      ST_JTAG_RD: begin
        mondreg_nxt  = ram_rddata;
        mon_addr_nxt = mon_addr + 8'd1;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM, monitor registers and JTAG slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      mon_addr <= 8'h0;
      MonDReg  <= 32'h0;
      slot_vld <= 1'b0;
      slot_op  <= OP_LOAD;
      slot_dat <= 32'h0;
    end else begin
      state    <= state_nxt;
      mon_addr <= mon_addr_nxt;
      MonDReg  <= mondreg_nxt;
      if (accept && !bypass) begin
        slot_vld <= 1'b1;
        slot_op  <= strb_op;
        slot_dat <= jdo[34:3];
      end else if (bypass && strb_op == OP_READ) begin
        slot_vld <= 1'b1;
        slot_op  <= OP_READ;
      end else if (retire_lw || state == ST_JTAG_RD) begin
        slot_vld <= 1'b0;
      end
    end
  end

  // Sticky overrun flag; a set event beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         jtag_overrun <= 1'b0;
    else if (overrun_set) jtag_overrun <= 1'b1;
    else if (clr_status)  jtag_overrun <= 1'b0;
  end

`ifdef CPU_DEBUG_OCIMEM_WP_EN
  // Sticky write-protect flag; a set event beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        wp_violation <= 1'b0;
    else if (wp_set)     wp_violation <= 1'b1;
    else if (clr_status) wp_violation <= 1'b0;
  end
`else
  logic [1:0] unused_dbg;
  assign unused_dbg   = {debugack, wp_set};
  assign wp_violation = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Directed bench for cpu_debug_ocimem_arbiter: CPU read data goes through a scoreboard queue
// checked by a monitor whenever a read completes; other results are compared directly.
module tb_cpu_debug_ocimem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        take_action_ocimem_a = 1'b0, take_action_ocimem_b = 1'b0, take_no_action_ocimem_a = 1'b0;
  logic [37:0] jdo = '0;
  logic        debugack = 1'b0, clr_status = 1'b0;
  logic [7:0]  av_address = '0;
  logic        av_read = 1'b0, av_write = 1'b0;
  logic [31:0] av_writedata = '0;
  logic [3:0]  av_byteenable = 4'hF;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_en, ram_wren;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_wrdata;
  logic [31:0] ram_rddata = '0;
  logic [31:0] MonDReg;
  logic [7:0]  mon_addr;
  logic        jtag_overrun, wp_violation;

  logic [31:0] mem [0:255];
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_dat = '0;

  logic [31:0] exp_q [$];
  int n_chk = 0;
  int n_fail = 0;

  cpu_debug_ocimem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_action_ocimem_a), .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a), .jdo(jdo),
    .debugack(debugack), .clr_status(clr_status),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_wren(ram_wren),
    .ram_byteenable(ram_byteenable), .ram_wrdata(ram_wrdata), .ram_rddata(ram_rddata),
    .MonDReg(MonDReg), .mon_addr(mon_addr),
    .jtag_overrun(jtag_overrun), .wp_violation(wp_violation)
  );

  always #5 clk = ~clk;

  // OCI RAM model: 1-cycle read latency, byte-enabled writes, plus a bench preload port.
  always @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_dat;
    end else begin
      if (ram_en) ram_rddata <= mem[ram_addr];
      if (ram_wren)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
    end
  end

  // Monitor: every completed CPU read must match the oldest expected value.
  always @(negedge clk) begin
    if (reset_n && av_read && !av_waitrequest) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cpu_rd_unexpected: got %h with no expected read", av_readdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (av_readdata !== e) begin
          n_fail++;
          $display("FAIL cpu_rd_data: got %h expected %h", av_readdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    load_addr = a;
    load_dat  = d;
    load_en   = 1'b1;
    tick();
    load_en   = 1'b0;
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] a);
    return {4'b0, a, 26'b0};
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    return {3'b0, d, 3'b0};
  endfunction

  // CPU read with the expected data queued for the monitor; counts wait-state cycles.
  task automatic cpu_read(input string nm, input logic [7:0] a, input logic also_write,
                          input logic [31:0] exp, input int exp_waits);
    int  waits;
    bit  done;
    tick();
    av_read      = 1'b1;
    av_write     = also_write;
    av_writedata = 32'h0;
    av_address   = a;
    exp_q.push_back(exp);
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (av_waitrequest) waits++;
      else done = 1'b1;
    end
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_waits"}, 32'(waits), 32'(exp_waits));
    tick();
    av_read  = 1'b0;
    av_write = 1'b0;
  endtask

  // CPU write: must complete in the issue cycle; exp_wren tells whether the RAM is written.
  task automatic cpu_write(input string nm, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic exp_wren);
    tick();
    av_write      = 1'b1;
    av_address    = a;
    av_writedata  = d;
    av_byteenable = be;
    @(negedge clk);
    check({nm, "_waitreq"}, 32'(av_waitrequest), 32'd0);
    check({nm, "_wren"}, 32'(ram_wren), 32'(exp_wren));
    tick();
    av_write      = 1'b0;
    av_byteenable = 4'hF;
  endtask

  initial begin
    poke(8'h00, 32'h0BADF00D);
    poke(8'h05, 32'h0);
    poke(8'h06, 32'h0);
    poke(8'h10, 32'h0);
    poke(8'h20, 32'hCAFEF00D);
    poke(8'h40, 32'h0);
    poke(8'h41, 32'h0);
    poke(8'hFF, 32'h12345678);

    // Reset values
    @(negedge clk);
    check("rst_waitreq", 32'(av_waitrequest), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_wren", 32'(ram_wren), 32'd0);
    check("rst_readdata", av_readdata, 32'h0);
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_mon_addr", 32'(mon_addr), 32'h0);
    check("rst_overrun", 32'(jtag_overrun), 32'd0);
    check("rst_wp", 32'(wp_violation), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Address load 0x10, then JTAG write DEADBEEF
    take_action_ocimem_a = 1'b1;
    jdo = jdo_addr(8'h10);
    @(negedge clk);
    check("load_no_ram", 32'(ram_en), 32'd0);
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b1;
    jdo = jdo_data(32'hDEADBEEF);
    @(negedge clk);
    check("jwr_wren", 32'(ram_wren), 32'd1);
    check("jwr_addr", 32'(ram_addr), 32'h10);
    check("jwr_be", 32'(ram_byteenable), 32'hF);
    check("jwr_data", ram_wrdata, 32'hDEADBEEF);
    tick();
    take_action_ocimem_b = 1'b0;
    @(negedge clk);
    check("jwr_mon_addr", 32'(mon_addr), 32'h11);
    check("jwr_mondreg", MonDReg, 32'hDEADBEEF);
    check("jwr_ram", mem[8'h10], 32'hDEADBEEF);
    check("jwr_no_overrun", 32'(jtag_overrun), 32'd0);

    // Plain CPU read of the freshly written word
    cpu_read("rd10", 8'h10, 1'b0, 32'hDEADBEEF, 1);

    // JTAG read with address wrap at 0xFF
    tick();
    take_action_ocimem_a = 1'b1;
    jdo = jdo_addr(8'hFF);
    tick();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    check("jrd_en", 32'(ram_en), 32'd1);
    check("jrd_addr", 32'(ram_addr), 32'hFF);
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    @(negedge clk);
    check("jrd_mondreg", MonDReg, 32'h12345678);
    check("jrd_wrap", 32'(mon_addr), 32'h00);

    // Overrun: back-to-back reads, second dropped while the first is in flight
    tick();
    take_no_action_ocimem_a = 1'b1;
    tick();
    tick();
    take_no_action_ocimem_a = 1'b0;
    @(negedge clk);
    check("ovr_mondreg", MonDReg, 32'h0BADF00D);
    check("ovr_mon_addr", 32'(mon_addr), 32'h01);
    check("ovr_flag", 32'(jtag_overrun), 32'd1);
    tick();
    tick();
    @(negedge clk);
    check("ovr_dropped", 32'(mon_addr), 32'h01);
    tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    @(negedge clk);
    check("ovr_clr", 32'(jtag_overrun), 32'd0);

    // Simultaneous strobes: load wins, write dropped; set beats a same-cycle clear
    tick();
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    clr_status = 1'b1;
    jdo = jdo_addr(8'h40);
    @(negedge clk);
    check("multi_no_wr", 32'(ram_wren), 32'd0);
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    clr_status = 1'b0;
    @(negedge clk);
    check("multi_mon_addr", 32'(mon_addr), 32'h40);
    check("multi_overrun", 32'(jtag_overrun), 32'd1);
    tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    @(negedge clk);
    check("multi_clr", 32'(jtag_overrun), 32'd0);

    // Contention: CPU read of 0x20 in the same cycle as a JTAG write
    tick();
    take_action_ocimem_b = 1'b1;
    jdo = jdo_data(32'h11111111);
    av_read = 1'b1;
    av_address = 8'h20;
    exp_q.push_back(32'hCAFEF00D);
    @(negedge clk);
    check("cont_jtag_first", 32'(ram_wren), 32'd1);
    check("cont_jtag_addr", 32'(ram_addr), 32'h40);
    check("cont_wait0", 32'(av_waitrequest), 32'd1);
    tick();
    take_action_ocimem_b = 1'b0;
    @(negedge clk);
    check("cont_wait1", 32'(av_waitrequest), 32'd1);
    check("cont_cpu_addr", 32'(ram_addr), 32'h20);
    tick();
    @(negedge clk);
    check("cont_done", 32'(av_waitrequest), 32'd0);
    tick();
    av_read = 1'b0;
    @(negedge clk);
    check("cont_ram", mem[8'h40], 32'h11111111);
    check("cont_mon_addr", 32'(mon_addr), 32'h41);
    check("idle_waitreq", 32'(av_waitrequest), 32'd0);

    // CPU writes: zero wait state, write protect depends on build
    debugack = 1'b0;
`ifdef CPU_DEBUG_OCIMEM_WP_EN
    cpu_write("wp_blk", 8'h05, 32'hA5A5A5A5, 4'hF, 1'b0);
    @(negedge clk);
    check("wp_ram_kept", mem[8'h05], 32'h0);
    check("wp_flag", 32'(wp_violation), 32'd1);
    debugack = 1'b1;
    cpu_write("wp_ok", 8'h05, 32'hA5A5A5A5, 4'hF, 1'b1);
    @(negedge clk);
    check("wp_ok_ram", mem[8'h05], 32'hA5A5A5A5);
`else
    cpu_write("cwr", 8'h05, 32'hA5A5A5A5, 4'hF, 1'b1);
    @(negedge clk);
    check("cwr_ram", mem[8'h05], 32'hA5A5A5A5);
    check("cwr_wp_tied", 32'(wp_violation), 32'd0);
    debugack = 1'b1;
`endif
    cpu_write("cwr_be", 8'h06, 32'hFFFFFFFF, 4'b0011, 1'b1);
    @(negedge clk);
    check("cwr_be_ram", mem[8'h06], 32'h0000FFFF);

    // av_read and av_write together: treated as a read
    cpu_read("rdwr", 8'h20, 1'b1, 32'hCAFEF00D, 1);
    @(negedge clk);
    check("rdwr_ram_kept", mem[8'h20], 32'hCAFEF00D);

    // Reset while in JTAG_RD
    tick();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst2_mondreg", MonDReg, 32'h0);
    check("rst2_mon_addr", 32'(mon_addr), 32'h0);
    check("rst2_ram_en", 32'(ram_en), 32'd0);
    check("rst2_ram_wren", 32'(ram_wren), 32'd0);
    check("rst2_waitreq", 32'(av_waitrequest), 32'd0);
    check("rst2_wp", 32'(wp_violation), 32'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst2_post_wren", 32'(ram_wren), 32'd0);
    tick();
    @(negedge clk);
    check("rst2_post_mondreg", MonDReg, 32'h0);
    check("rst2_post_mon_addr", 32'(mon_addr), 32'h0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
